// File: rtl/hazard_pkg.sv
// Shared types and sizing helpers for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {IDLE, HAZ_STALL, SYS_DRAIN, SYS_WAIT} haz_state_t;

    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_HAZ_STAGE  = 1;
    localparam int DEF_HAZ_CYCLES = 1;

    // Counter must hold both the stall length and the drain length.
    function automatic int cnt_width(input int haz_cycles, input int num_stages);
        int m;
        m = (haz_cycles > num_stages) ? haz_cycles : num_stages;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl.sv
// Converts forwarding-stall and syscall requests into per-register stall/flush
// vectors; syscalls drain the pipe and hold Syscall_OUT until acknowledged.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int HAZ_STAGE  = DEF_HAZ_STAGE,
    parameter int HAZ_CYCLES = DEF_HAZ_CYCLES
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  STALL_IN,
    input  logic                  Syscall_IN,
    input  logic                  Syscall_ACK,
    output logic [NUM_STAGES-1:0] STALL,
    output logic [NUM_STAGES-1:0] FLUSH,
    output logic                  Syscall_OUT,
    output logic                  BUSY
);

    localparam int CW = cnt_width(HAZ_CYCLES, NUM_STAGES);
    localparam logic [CW-1:0] HAZ_LOAD = CW'(HAZ_CYCLES);
    localparam logic [CW-1:0] SYS_LOAD = CW'(NUM_STAGES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    generate
        if (NUM_STAGES < 2) begin : g_chk_stages
            $error("NUM_STAGES must be >= 2");
        end
        if (HAZ_STAGE < 1 || HAZ_STAGE > NUM_STAGES - 1) begin : g_chk_haz_stage
            $error("HAZ_STAGE must be in 1..NUM_STAGES-1");
        end
        if (HAZ_CYCLES < 1) begin : g_chk_haz_cycles
            $error("HAZ_CYCLES must be >= 1");
        end
    endgenerate

    haz_state_t            state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [NUM_STAGES-1:0] stall_nxt, flush_nxt;
    logic                  sys_out_nxt;

    // Outputs are decoded from next-state so they change on the request edge.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            STALL       <= '0;
            FLUSH       <= '0;
            Syscall_OUT <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            STALL       <= stall_nxt;
            FLUSH       <= flush_nxt;
            Syscall_OUT <= sys_out_nxt;
            BUSY        <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (Syscall_IN) begin
                    state_nxt = SYS_DRAIN;
                    cnt_nxt   = SYS_LOAD;
                end else if (STALL_IN) begin
                    state_nxt = HAZ_STALL;
                    cnt_nxt   = HAZ_LOAD;
                end
            end
            HAZ_STALL: begin
                if (Syscall_IN) begin
                    state_nxt = SYS_DRAIN;
                    cnt_nxt   = SYS_LOAD;
                end else if (STALL_IN) begin
                    cnt_nxt   = HAZ_LOAD;
                end else if (cnt == CNT_ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt - CNT_ONE;
                end
            end
            SYS_DRAIN: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) state_nxt = SYS_WAIT;
            end
            SYS_WAIT: begin
                if (Syscall_ACK) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        stall_nxt   = '0;
        flush_nxt   = '0;
        sys_out_nxt = 1'b0;
        case (state_nxt)
            HAZ_STALL: begin
                for (int i = 0; i < HAZ_STAGE; i++) stall_nxt[i] = 1'b1;
                flush_nxt[HAZ_STAGE] = 1'b1;
            end
            SYS_DRAIN, SYS_WAIT: begin
                // Register 0 is both held and squashed: the fetched successor is discarded.
                stall_nxt[0] = 1'b1;
                flush_nxt[0] = 1'b1;
                flush_nxt[1] = 1'b1;
                sys_out_nxt  = (state_nxt == SYS_WAIT);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector bench for pipeline_hazard_ctrl across three parameter sets.
module tb_pipeline_hazard_ctrl;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    logic STALL_IN = 1'b0, Syscall_IN = 1'b0, Syscall_ACK = 1'b0;

    logic [3:0] stall_a, flush_a;
    logic       so_a, busy_a;
    logic [3:0] stall_b, flush_b;
    logic       so_b, busy_b;
    logic [5:0] stall_c, flush_c;
    logic       so_c, busy_c;

    int errors = 0;
    int checks = 0;

    always #5 CLOCK = ~CLOCK;

    pipeline_hazard_ctrl dut_a (
        .CLOCK(CLOCK), .RESET(RESET), .STALL_IN(STALL_IN), .Syscall_IN(Syscall_IN),
        .Syscall_ACK(Syscall_ACK), .STALL(stall_a), .FLUSH(flush_a),
        .Syscall_OUT(so_a), .BUSY(busy_a)
    );

    pipeline_hazard_ctrl #(.NUM_STAGES(4), .HAZ_STAGE(2), .HAZ_CYCLES(3)) dut_b (
        .CLOCK(CLOCK), .RESET(RESET), .STALL_IN(STALL_IN), .Syscall_IN(Syscall_IN),
        .Syscall_ACK(Syscall_ACK), .STALL(stall_b), .FLUSH(flush_b),
        .Syscall_OUT(so_b), .BUSY(busy_b)
    );

    pipeline_hazard_ctrl #(.NUM_STAGES(6)) dut_c (
        .CLOCK(CLOCK), .RESET(RESET), .STALL_IN(STALL_IN), .Syscall_IN(Syscall_IN),
        .Syscall_ACK(Syscall_ACK), .STALL(stall_c), .FLUSH(flush_c),
        .Syscall_OUT(so_c), .BUSY(busy_c)
    );

    typedef struct {
        logic       stall_in, sys_in, ack;
        logic [3:0] stall, flush;
        logic       sys_out, busy;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, sample 1 time unit after the rising edge.
    task automatic drive(input logic s, input logic y, input logic a);
        STALL_IN = s; Syscall_IN = y; Syscall_ACK = a;
        @(posedge CLOCK);
        #1;
        STALL_IN = 1'b0; Syscall_IN = 1'b0; Syscall_ACK = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        repeat (2) @(posedge CLOCK);
        #3;
        RESET = 1'b1;
    endtask

    task automatic check_a(input string n, input logic [3:0] s, input logic [3:0] f,
                           input logic o, input logic b);
        check({n, ".stall"}, {4'h0, stall_a}, {4'h0, s});
        check({n, ".flush"}, {4'h0, flush_a}, {4'h0, f});
        check({n, ".sysout"}, {7'h0, so_a}, {7'h0, o});
        check({n, ".busy"}, {7'h0, busy_a}, {7'h0, b});
    endtask

    initial begin
        //          s  y  a   stall    flush    so busy
        tbl[0]  = '{1, 0, 0, 4'b0001, 4'b0010, 0, 1};
        tbl[1]  = '{0, 0, 0, 4'b0000, 4'b0000, 0, 0};
        tbl[2]  = '{1, 0, 0, 4'b0001, 4'b0010, 0, 1};
        tbl[3]  = '{1, 0, 0, 4'b0001, 4'b0010, 0, 1};
        tbl[4]  = '{0, 0, 0, 4'b0000, 4'b0000, 0, 0};
        tbl[5]  = '{1, 1, 0, 4'b0001, 4'b0011, 0, 1};
        tbl[6]  = '{1, 1, 1, 4'b0001, 4'b0011, 0, 1};
        tbl[7]  = '{0, 0, 0, 4'b0001, 4'b0011, 0, 1};
        tbl[8]  = '{0, 0, 1, 4'b0001, 4'b0011, 1, 1};
        tbl[9]  = '{0, 0, 0, 4'b0001, 4'b0011, 1, 1};
        tbl[10] = '{0, 1, 1, 4'b0000, 4'b0000, 0, 0};
        tbl[11] = '{0, 1, 0, 4'b0001, 4'b0011, 0, 1};
        tbl[12] = '{0, 0, 0, 4'b0001, 4'b0011, 0, 1};
        tbl[13] = '{0, 0, 0, 4'b0001, 4'b0011, 0, 1};
        tbl[14] = '{0, 0, 0, 4'b0001, 4'b0011, 1, 1};
        tbl[15] = '{0, 0, 1, 4'b0000, 4'b0000, 0, 0};
        tbl[16] = '{1, 0, 0, 4'b0001, 4'b0010, 0, 1};
        tbl[17] = '{0, 1, 0, 4'b0001, 4'b0011, 0, 1};
        tbl[18] = '{0, 0, 0, 4'b0001, 4'b0011, 0, 1};
        tbl[19] = '{0, 0, 0, 4'b0001, 4'b0011, 0, 1};
        tbl[20] = '{0, 0, 0, 4'b0001, 4'b0011, 1, 1};
        tbl[21] = '{0, 0, 1, 4'b0000, 4'b0000, 0, 0};

        // Reset state and idle cycles
        #1;
        check_a("in_reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0);
            check_a($sformatf("idle%0d", i), 4'b0000, 4'b0000, 1'b0, 1'b0);
        end

        // Default-parameter vector table
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].stall_in, tbl[i].sys_in, tbl[i].ack);
            check_a($sformatf("vec%0d", i), tbl[i].stall, tbl[i].flush, tbl[i].sys_out, tbl[i].busy);
        end

        // HAZ_CYCLES=3, HAZ_STAGE=2: isolated pulse
        do_reset();
        drive(0, 0, 0);
        drive(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(0, 0, 0);
            check($sformatf("b_pulse_stall%0d", i), {4'h0, stall_b}, (i < 3) ? 8'h03 : 8'h00);
            check($sformatf("b_pulse_flush%0d", i), {4'h0, flush_b}, (i < 3) ? 8'h04 : 8'h00);
        end

        // Pulses two edges apart merge into one 5-cycle stall
        drive(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive((i == 0 || i == 2), 0, 0);
            check($sformatf("b_ext_stall%0d", i), {4'h0, stall_b}, (i < 5) ? 8'h03 : 8'h00);
            check($sformatf("b_ext_busy%0d", i), {7'h0, busy_b}, (i < 5) ? 8'h01 : 8'h00);
        end

        // NUM_STAGES=6: drain takes 5 cycles
        do_reset();
        drive(0, 1, 0);
        check("c_entry_stall", {2'b0, stall_c}, 8'h01);
        check("c_entry_flush", {2'b0, flush_c}, 8'h03);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0);
            check($sformatf("c_sysout%0d", i), {7'h0, so_c}, (i == 5) ? 8'h01 : 8'h00);
        end
        drive(0, 0, 1);
        check("c_ack_busy", {7'h0, busy_c}, 8'h00);
        check("c_ack_flush", {2'b0, flush_c}, 8'h00);

        // Asynchronous reset while dut_a waits for ACK
        do_reset();
        drive(0, 1, 0);
        repeat (3) drive(0, 0, 0);
        check("a_in_wait", {7'h0, so_a}, 8'h01);
        #1;
        RESET = 1'b0;
        #2;
        check_a("async_rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
        check("async_rst_c_busy", {7'h0, busy_c}, 8'h00);
        RESET = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard controller for the N-stage MIPS pipeline. It sits between the forwarding unit, the decode stage and the pipeline registers. It converts single-cycle hazard and syscall requests into per-register stall/flush vectors. Syscalls are handled with a full drain-and-handshake sequence: older instructions retire, fetch is frozen, `Syscall_OUT` is held until the environment acknowledges. Replaces the fixed 4-register, ring-counter hazard logic.

## Interface
- `NUM_STAGES`, default 4: number of pipeline registers. Index 0 = IF/ID, index NUM_STAGES-1 = last (MEM/WB). Legal range is ≥2.
- `HAZ_STAGE`, default 1: first register that receives a bubble on a forwarding stall. Registers 0..HAZ_STAGE-1 are stalled. Legal range is 1..NUM_STAGES-1.
- `HAZ_CYCLES`, default 1: length of a forwarding stall in cycles. Must be ≥1.
- `CLOCK` in 1: single clock. All state updates on the rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `STALL_IN` in 1: forwarding-unit hazard request, sampled each rising edge.
- `Syscall_IN` in 1: decode stage holds a syscall, sampled each rising edge.
- `Syscall_ACK` in 1: environment has serviced the syscall.
- `STALL` out NUM_STAGES: per-register hold enable.
- `FLUSH` out NUM_STAGES: per-register bubble insert. Within a register, flush overrides stall.
- `Syscall_OUT` out 1: pipeline drained, syscall pending service.
- `BUSY` out 1: controller is not in IDLE.

## Operation
- FSM states: IDLE, HAZ_STALL, SYS_DRAIN, SYS_WAIT. State, counter and all outputs are registered.
- Down-counter `cnt` is $clog2(max(HAZ_CYCLES, NUM_STAGES)+1) bits wide. It never wraps; a load happens only on state entry or reload.
- IDLE:
  - All outputs 0.
  - `Syscall_IN` → SYS_DRAIN with cnt = NUM_STAGES-1. This takes priority over `STALL_IN`.
  - Otherwise `STALL_IN` → HAZ_STALL with cnt = HAZ_CYCLES.
- HAZ_STALL:
  - Outputs: STALL[HAZ_STAGE-1:0]=1, FLUSH[HAZ_STAGE]=1, all other bits 0.
  - Each cycle cnt decrements.
  - `STALL_IN` reloads cnt = HAZ_CYCLES, extending the stall.
  - `Syscall_IN` preempts: go to SYS_DRAIN and load cnt.
  - When cnt reaches 1 with no reload, go to IDLE.
- SYS_DRAIN:
  - Outputs: STALL[0]=1, FLUSH[1]=1. FLUSH[0]=1 squashes the fetched successor.
  - Older instructions advance and retire.
  - cnt decrements; at cnt==1 go to SYS_WAIT.
  - `STALL_IN` and further `Syscall_IN` are ignored.
- SYS_WAIT:
  - Same STALL/FLUSH outputs as SYS_DRAIN, plus `Syscall_OUT`=1.
  - `Syscall_ACK` sampled high → IDLE.
- `Syscall_ACK` outside SYS_WAIT is ignored.
- `BUSY` = (state != IDLE).
- Reset (RESET=0, any state, mid-sequence included): state IDLE, cnt 0, STALL=0, FLUSH=0, Syscall_OUT=0, BUSY=0, immediately and asynchronously. Any pending syscall is abandoned.

## Timing
- Latency: a request sampled at edge t drives outputs from just after edge t. Outputs are valid for the cycle between edge t and edge t+1.
- Forwarding stall: outputs are active for exactly HAZ_CYCLES cycles per isolated request. A request arriving on the last active cycle extends the stall contiguously, with no gap.
- Syscall: drain lasts NUM_STAGES-1 cycles. `Syscall_OUT` rises NUM_STAGES-1 cycles after entry and holds until the ACK edge. Outputs clear on the cycle after ACK is sampled.
- ACK asserted on the edge that enters SYS_WAIT is not seen, because the state is still SYS_DRAIN at that edge.
- Simultaneous `STALL_IN` and `Syscall_IN` in IDLE or HAZ_STALL: syscall wins, and the stall request is dropped.
- A back-to-back syscall (`Syscall_IN` on the ACK edge) is ignored. Decode re-presents it after release and it is accepted the following edge.

## Structure
- Package `hazard_pkg`:
  - state enum `haz_state_t` {IDLE, HAZ_STALL, SYS_DRAIN, SYS_WAIT}
  - function `cnt_width(haz_cycles, num_stages)`
  - default parameter constants
- Single module with no sub-modules. Output decode is a registered function of next-state.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
- Reset release, no requests:
  - STALL=0000, FLUSH=0000, Syscall_OUT=0, BUSY=0 for 10 cycles.
  - Assert RESET=0 mid-SYS_WAIT: all outputs 0 with no clock edge.
- `STALL_IN` pulse at edge 5, defaults:
  - STALL=0001, FLUSH=0010 for exactly 1 cycle, then all 0.
  - Repeat with HAZ_CYCLES=3, HAZ_STAGE=2: STALL=0011, FLUSH=0100 for 3 cycles.
- `STALL_IN` pulses at edges 5 and 7 with HAZ_CYCLES=3:
  - One contiguous stall of 5 cycles.
  - BUSY is high throughout.
- `Syscall_IN` at edge 10, defaults:
  - STALL=0001, FLUSH=0011 from edge 10.
  - Syscall_OUT rises after edge 13.
  - ACK at edge 20: all outputs 0 after edge 20.
  - NUM_STAGES=6: Syscall_OUT rises after edge 15.
- `STALL_IN` and `Syscall_IN` both at edge 4:
  - Syscall sequence only.
  - A further `STALL_IN` and `Syscall_IN` during SYS_DRAIN are ignored.
  - ACK during SYS_DRAIN is ignored; Syscall_OUT still rises on schedule.
